// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM encodings and the rcon update used
// by the iterative key expansion.
package aes_pkg;

   localparam logic AES_128_BIT_KEY = 1'b0;
   localparam logic AES_256_BIT_KEY = 1'b1;

   localparam logic [3:0] AES128_ROUNDS = 4'ha;
   localparam logic [3:0] AES256_ROUNDS = 4'he;

   typedef enum logic [1:0] {
      KS_IDLE = 2'd0,
      KS_INIT = 2'd1,
      KS_GEN  = 2'd2,
      KS_DONE = 2'd3
   } ks_state_t;

   // Multiply by x in GF(2^8); starting from 8'h8d the first step yields 8'h01.
   function automatic logic [7:0] rcon_next(input logic [7:0] rc);
      return {rc[6:0], 1'b0} ^ (8'h1b & {8{rc[7]}});
   endfunction

endpackage

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/256 key expansion: one round key per cycle into a local
// store that is read combinationally by round index.
module aes_key_schedule
   import aes_pkg::*;
#(
   parameter int NUM_KEYS = 15
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         init,
   input  logic [255:0] key,
   input  logic         keylen,
   input  logic [3:0]   round,
   output logic [127:0] round_key,
   output logic         ready,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw
);

   // Handshake: ready is high when the store holds a complete expansion and
   // the block is idle; init is accepted only while idle, and ready drops the
   // cycle after init is taken and rises again once the last key is written.

   ks_state_t      state, state_next;
   logic [127:0]   key_mem [NUM_KEYS];
   logic [255:0]   key_reg;
   logic           keylen_reg;
   logic [3:0]     round_ctr;
   logic [7:0]     rcon;
   logic [127:0]   prev_key0, prev_key1;

   logic [3:0]     last_idx;
   logic           odd256, direct;
   logic [127:0]   q;
   logic [31:0]    t, w0, w1, w2, w3;
   logic [7:0]     rcon_nxt;
   logic [127:0]   new_key;

   assign last_idx = keylen_reg ? AES256_ROUNDS : AES128_ROUNDS;
   assign round_key = (int'(round) < NUM_KEYS) ? key_mem[round] : 128'h0;

   always_comb begin
      state_next = state;
      case (state)
         KS_IDLE: if (init) state_next = KS_INIT;
         KS_INIT: state_next = KS_GEN;
         KS_GEN:  if (round_ctr == last_idx) state_next = KS_DONE;
         KS_DONE: state_next = KS_IDLE;
         default: state_next = KS_IDLE;
      endcase
   end

   // Round keys 0 (and 1 for AES-256) come straight from the cipher key; the
   // rest are derived from the previous one or two keys through the S-box.
   always_comb begin
      odd256   = keylen_reg && round_ctr[0];
      direct   = (round_ctr == 4'd0) || (keylen_reg && round_ctr == 4'd1);
      q        = keylen_reg ? prev_key0 : prev_key1;
      rcon_nxt = rcon_next(rcon);
      sboxw    = 32'h0;
      if (state == KS_GEN && !direct)
         sboxw = odd256 ? prev_key1[31:0] : {prev_key1[23:0], prev_key1[31:24]};
      t  = odd256 ? new_sboxw : (new_sboxw ^ {rcon_nxt, 24'h0});
      w0 = q[127:96] ^ t;
      w1 = q[95:64]  ^ w0;
      w2 = q[63:32]  ^ w1;
      w3 = q[31:0]   ^ w2;
      if (round_ctr == 4'd0)
         new_key = key_reg[255:128];
      else if (direct)
         new_key = key_reg[127:0];
      else
         new_key = {w0, w1, w2, w3};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= KS_IDLE;
         ready      <= 1'b1;
         key_reg    <= 256'h0;
         keylen_reg <= 1'b0;
         round_ctr  <= 4'd0;
         rcon       <= 8'h8d;
         prev_key0  <= 128'h0;
         prev_key1  <= 128'h0;
         for (int i = 0; i < NUM_KEYS; i++) key_mem[i] <= 128'h0;
      end else begin
         state <= state_next;
         case (state)
            KS_IDLE: begin
               if (init) begin
                  key_reg    <= key;
                  keylen_reg <= keylen;
                  ready      <= 1'b0;
               end
            end
            KS_INIT: begin
               round_ctr <= 4'd0;
               rcon      <= 8'h8d;
            end
            KS_GEN: begin
               key_mem[round_ctr] <= new_key;
               prev_key0          <= prev_key1;
               prev_key1          <= new_key;
               round_ctr          <= round_ctr + 4'd1;
               if (!direct && !odd256) rcon <= rcon_nxt;
            end
            KS_DONE: ready <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: S-box model on the sboxw port, FIPS-197 vectors
// and a reference key expansion feeding an expected-key scoreboard.
module tb_aes_key_schedule;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY256 =
      256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic         clk = 1'b0;
   logic         reset;
   logic         init;
   logic [255:0] key;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic         ready;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;

   int checks = 0;
   int failures = 0;

   logic [127:0] exp_q[$];
   logic [3:0]   idx_q[$];
   logic [127:0] model_keys [15];

   aes_key_schedule #(.NUM_KEYS(15)) dut (
      .clk(clk), .reset(reset), .init(init), .key(key), .keylen(keylen),
      .round(round), .round_key(round_key), .ready(ready),
      .sboxw(sboxw), .new_sboxw(new_sboxw)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBOX[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
   endfunction

   always_comb new_sboxw = subw(sboxw);

   // Reference FIPS-197 word-wise expansion.
   task automatic model_expand(input logic [255:0] k, input logic kl);
      logic [31:0] w [60];
      logic [31:0] temp;
      logic [7:0]  rc;
      int nk, nr;
      nk = kl ? 8 : 4;
      nr = kl ? 14 : 10;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         temp = w[i-1];
         if (i % nk == 0) begin
            temp = subw({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
            rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % nk == 4) begin
            temp = subw(temp);
         end
         w[i] = w[i-nk] ^ temp;
      end
      for (int r = 0; r <= nr; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic push_model(input int n);
      for (int r = 0; r < n; r++) begin
         exp_q.push_back(model_keys[r]);
         idx_q.push_back(4'(r));
      end
   endtask

   task automatic read_key(input logic [3:0] r, output logic [127:0] v);
      @(negedge clk);
      round = r;
      #1 v = round_key;
   endtask

   // Pulse init at a negedge (cycle 0) and count cycles until ready is seen high.
   task automatic start_and_wait(input logic [255:0] k, input logic kl, output int cyc);
      @(negedge clk);
      key = k; keylen = kl; init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      cyc = 1;
      while (!ready && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset;
      logic [127:0] got;
      reset = 1'b1; init = 1'b0; key = '0; keylen = 1'b0; round = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++;
      if (sboxw !== 32'h0) begin failures++; $display("FAIL reset_sboxw got=%h exp=0", sboxw); end
      @(negedge clk) reset = 1'b0;
      for (int r = 0; r < 16; r++) begin
         read_key(4'(r), got);
         checks++;
         if (got !== 128'h0) begin
            failures++; $display("FAIL reset_store round %0d got=%h exp=0", r, got);
         end
      end
   endtask

   task automatic test_aes256;
      int cyc;
      logic [127:0] got, e;
      logic [3:0] r;
      exp_q.push_back(128'h603deb1015ca71be2b73aef0857d7781); idx_q.push_back(4'd0);
      exp_q.push_back(128'h1f352c073b6108d72d9810a30914dff4); idx_q.push_back(4'd1);
      exp_q.push_back(128'h9ba354118e6925afa51a8b5f2067fcde); idx_q.push_back(4'd2);
      exp_q.push_back(128'hfe4890d1e6188d0b046df344706c631e); idx_q.push_back(4'd14);
      exp_q.push_back(128'h0); idx_q.push_back(4'd15);
      model_expand(KEY256, 1'b1);
      push_model(15);
      start_and_wait(KEY256, 1'b1, cyc);
      checks++;
      if (cyc !== 18) begin failures++; $display("FAIL aes256_latency got=%0d exp=18", cyc); end
      while (exp_q.size() > 0) begin
         r = idx_q.pop_front(); e = exp_q.pop_front();
         read_key(r, got);
         checks++;
         if (got !== e) begin failures++; $display("FAIL aes256_key round %0d got=%h exp=%h", r, got, e); end
      end
   endtask

   task automatic test_aes128;
      int cyc;
      logic [127:0] got, e;
      logic [3:0] r;
      // Entries 11..14 must still hold the previous AES-256 expansion.
      for (int i = 11; i < 15; i++) begin exp_q.push_back(model_keys[i]); idx_q.push_back(4'(i)); end
      exp_q.push_back(128'h2b7e151628aed2a6abf7158809cf4f3c); idx_q.push_back(4'd0);
      exp_q.push_back(128'ha0fafe1788542cb123a339392a6c7605); idx_q.push_back(4'd1);
      exp_q.push_back(128'hd014f9a8c9ee2589e13f0cc8b6630ca6); idx_q.push_back(4'd10);
      model_expand(KEY128, 1'b0);
      push_model(11);
      start_and_wait(KEY128, 1'b0, cyc);
      checks++;
      if (cyc !== 14) begin failures++; $display("FAIL aes128_latency got=%0d exp=14", cyc); end
      while (exp_q.size() > 0) begin
         r = idx_q.pop_front(); e = exp_q.pop_front();
         read_key(r, got);
         checks++;
         if (got !== e) begin failures++; $display("FAIL aes128_key round %0d got=%h exp=%h", r, got, e); end
      end
   endtask

   task automatic test_ignore_midgen;
      int cyc;
      logic [127:0] got, e;
      logic [3:0] r;
      model_expand(KEY256, 1'b1);
      push_model(15);
      @(negedge clk);
      key = KEY256; keylen = 1'b1; init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      repeat (5) @(negedge clk);
      key = KEY128; keylen = 1'b0; round = 4'd3; init = 1'b1;
      @(negedge clk);
      init = 1'b0; key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cyc = 7;
      while (!ready && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (cyc !== 18) begin failures++; $display("FAIL midgen_latency got=%0d exp=18", cyc); end
      while (exp_q.size() > 0) begin
         r = idx_q.pop_front(); e = exp_q.pop_front();
         read_key(r, got);
         checks++;
         if (got !== e) begin failures++; $display("FAIL midgen_key round %0d got=%h exp=%h", r, got, e); end
      end
   endtask

   task automatic test_reset_midgen;
      int cyc;
      logic [127:0] got, e;
      logic [255:0] k;
      logic [3:0] r;
      @(negedge clk);
      key = KEY128; keylen = 1'b0; init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      repeat (6) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", ready); end
      for (int i = 0; i < 15; i++) begin
         round = 4'(i);
         #1;
         checks++;
         if (round_key !== 128'h0) begin
            failures++; $display("FAIL midreset_store round %0d got=%h exp=0", i, round_key);
         end
      end
      @(negedge clk) reset = 1'b0;
      k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
      model_expand(k, 1'b0);
      push_model(11);
      start_and_wait(k, 1'b0, cyc);
      checks++;
      if (cyc !== 14) begin failures++; $display("FAIL midreset_latency got=%0d exp=14", cyc); end
      while (exp_q.size() > 0) begin
         r = idx_q.pop_front(); e = exp_q.pop_front();
         read_key(r, got);
         checks++;
         if (got !== e) begin failures++; $display("FAIL midreset_key round %0d got=%h exp=%h", r, got, e); end
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      logic [127:0] got, e;
      logic [255:0] k;
      logic kl;
      logic [3:0] r;
      for (int n = 0; n < 6; n++) begin
         k  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         kl = 1'($urandom_range(0, 1));
         if (!kl) k[127:0] = '0;
         model_expand(k, kl);
         push_model(kl ? 15 : 11);
         start_and_wait(k, kl, cyc);
         checks++;
         if (cyc !== (kl ? 18 : 14)) begin
            failures++; $display("FAIL b2b_latency iter %0d got=%0d exp=%0d", n, cyc, kl ? 18 : 14);
         end
         while (exp_q.size() > 0) begin
            r = idx_q.pop_front(); e = exp_q.pop_front();
            read_key(r, got);
            checks++;
            if (got !== e) begin
               failures++; $display("FAIL b2b_key iter %0d round %0d got=%h exp=%h", n, r, got, e);
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_aes256;
      test_aes128;
      test_ignore_midgen;
      test_reset_midgen;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Iterative AES key expansion and round-key store.
- Expands a 128- or 256-bit cipher key into 11 or 15 round keys, one per cycle, and holds them in an internal register file.
- Serves round_key combinationally to aes_decipher_block, which indexes by its round output while counting down from 10/14 to 0.
- SubWord uses a shared external S-box through the sboxw/new_sboxw port pair.

Parameters:
- NUM_KEYS, 15, depth of the round-key store (AES-256 maximum).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- init  in  1  start expansion; single-cycle pulse, sampled only in IDLE
- key  in  256  cipher key; AES-128 uses key[255:128]
- keylen  in  1  0 = AES-128, 1 = AES-256; sampled with init
- round  in  4  round-key index
- round_key  out  128  key_mem[round]; 0 when round >= NUM_KEYS
- ready  out  1  1 = store valid and idle
- sboxw  out  32  word to the external forward S-box
- new_sboxw  in  32  S-box result; combinational, same cycle

Interface note (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (asynchronous, any time including mid-expansion):
  - state = IDLE, ready = 1, all key_mem entries = 0.
  - round_ctr = 0, rcon = 8'h8d, prev_key0/prev_key1 = 0, sboxw = 0.
  - A partial expansion is abandoned.
- FSM states: IDLE, INIT, GEN, DONE.
- IDLE:
  - On init, latch key and keylen into key_reg/keylen_reg, clear ready, go to INIT.
  - init in any other state is ignored.
- INIT (1 cycle):
  - round_ctr = 0, rcon = 8'h8d.
  - nkeys = 11 (AES-128) or 15 (AES-256), taken from keylen_reg.
- GEN (one key written per cycle, key_mem[round_ctr] <= k):
  - round_ctr 0: k = key_reg[255:128].
  - round_ctr 1, AES-256 only: k = key_reg[127:0].
  - Otherwise, with p = prev_key1 and q = (AES-256 ? prev_key0 : prev_key1):
    - t = SubWord(RotWord(p.w3)) ^ {rcon_next, 24'h0}, and rcon <= rcon_next.
    - Exception: AES-256 with odd round_ctr uses t = SubWord(p.w3), and rcon is left unchanged.
    - k.w0 = q.w0 ^ t; k.w1 = q.w1 ^ k.w0; k.w2 = q.w2 ^ k.w1; k.w3 = q.w3 ^ k.w2.
  - rcon_next = {rcon[6:0], 0} ^ (8'h1b & {8{rcon[7]}}). This yields the sequence 01, 02, 04, ... 80, 1b, 36.
  - After each write: prev_key0 <= prev_key1, prev_key1 <= k, round_ctr++.
  - When round_ctr == nkeys-1 is written, go to DONE.
- sboxw: driven with RotWord(prev_key1.w3) or prev_key1.w3 as the rule above requires during GEN; 0 otherwise.
- DONE (1 cycle): ready <= 1, go to IDLE.
- Latency: init sampled at cycle 0 → ready = 1 at cycle 14 (AES-128) or cycle 18 (AES-256).
- During expansion:
  - round_key reflects the store as being written; stale entries are not cleared.
  - Changes to key, keylen or round have no effect on the expansion.
- In AES-128 mode, entries 11..14 keep prior contents.

Decomposition:
- Shared package aes_pkg holds:
  - AES_128_BIT_KEY / AES_256_BIT_KEY
  - AES128_ROUNDS (4'ha) / AES256_ROUNDS (4'he)
  - key-schedule state encodings
  - the gm2-style rcon_next function
- The S-box remains the existing shared aes_sbox instance at the core level.
- No internal sub-module; RotWord/SubWord glue stays inline.

Test Plan:
- Reset then idle: after reset, ready = 1, round_key = 0 for round = 0..15, sboxw = 0.
- FIPS-197 A.1 AES-128, key[255:128] = 2b7e151628aed2a6abf7158809cf4f3c, pulse init:
  - ready low for exactly 14 cycles.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- FIPS-197 A.3 AES-256, key = 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, keylen = 1:
  - round 1 = 1f352c073b6108d72d9810a30914dff4.
  - round 2 = 9ba354118e6925afa51a8b5f2067fcde.
  - round 14 = fe4890d1e6188d0b046df344706c631e.
  - ready after 18 cycles.
- init pulsed mid-GEN, and key/keylen changed mid-GEN → ignored; final keys still match the vector of the original init.
- reset asserted at GEN cycle 5 → ready = 1 and store = 0 immediately. A new AES-128 init then produces correct keys.
- Downstream integration: aes_decipher_block fed from this store decrypts 3925841d02dc09fbdc118597196a0b32 to 3243f6a8885a308d313198a2e0370734.
